// File: rtl/q2_pkg.sv
// Shared definitions for the q2 bit-serial ALU sequencer: opcodes, FSM states, flag seeding.
package q2_pkg;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_NOR  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // LOAD/NOR seed the zero-detect with 1; ADD seeds carry; SHR seeds the bit shifted out.
    function automatic logic flag_init(input logic [1:0] op, input logic cin, input logic x0);
        logic f;
        f = 1'b1;
        case (op)
            OP_ADD:  f = cin;
            OP_SHR:  f = x0;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/q2_shreg.sv
// WIDTH-bit right shift register with parallel load and serial input at the MSB.
// Load has priority over shift; one-cycle update, no backpressure.
module q2_shreg #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (shift_i) begin
            sh_d = {ser_i, sh_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q_o = sh_q;

endmodule

// File: rtl/q2_alu_seq.sv
// Bit-serial operand sequencer driving the q2 single-bit ALU slice, LSB first.
// Latency: res_valid WIDTH cycles after accept; one op per WIDTH+2 cycles, op_ready only in IDLE.
// Optional golden-model self-check under Q2_ALU_SEQ_SELFCHECK_EN (otherwise chk_err tied 0).
module q2_alu_seq
    import q2_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] x_in,
    input  logic             cin,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_flag,
    output logic             alu_a0,
    output logic             alu_x0,
    output logic             alu_x1,
    output logic             alu_f,
    output logic             alu_o0,
    output logic             alu_o1,
    input  logic             alu_out,
    input  logic             alu_cout,
    output logic             chk_err
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             flag_q, flag_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_flag_q, res_flag_d;
    logic [WIDTH-1:0] a_q, x_q;
    logic             accept, run, last;

    assign run    = (state_q == ST_RUN);
    assign accept = op_valid && (state_q == ST_IDLE);
    assign last   = (cnt_q == CW'(WIDTH - 1));

    // A recirculates the slice result; X just drains towards zero.
    q2_shreg #(.WIDTH(WIDTH)) u_a_sh (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .data_i  (a_in),
        .shift_i (run),
        .ser_i   (alu_out),
        .q_o     (a_q)
    );

    q2_shreg #(.WIDTH(WIDTH)) u_x_sh (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .data_i  (x_in),
        .shift_i (run),
        .ser_i   (1'b0),
        .q_o     (x_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last)   state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = (state_q == ST_IDLE);
        res_valid = (state_q == ST_DONE);
        alu_a0    = 1'b0;
        alu_x0    = 1'b0;
        alu_x1    = 1'b0;
        alu_f     = 1'b0;
        alu_o0    = 1'b0;
        alu_o1    = 1'b0;
        if (run) begin
            alu_a0 = a_q[0];
            alu_x0 = x_q[0];
            alu_x1 = last ? 1'b0 : x_q[1];
            alu_f  = flag_q;
            alu_o0 = op_q[0];
            alu_o1 = op_q[1];
        end
    end

    // The result is captured on the final RUN edge so it is stable for the whole DONE cycle
    // and survives the A register being reloaded by the next accept.
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        flag_d     = flag_q;
        res_data_d = res_data_q;
        res_flag_d = res_flag_q;
        if (accept) begin
            cnt_d  = '0;
            op_d   = op_code;
            flag_d = flag_init(op_code, cin, x_in[0]);
        end else if (run) begin
            cnt_d  = cnt_q + CW'(1);
            flag_d = alu_cout;
            if (last) begin
                res_data_d = {alu_out, a_q[WIDTH-1:1]};
                res_flag_d = alu_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            op_q       <= '0;
            flag_q     <= 1'b0;
            res_data_q <= '0;
            res_flag_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            flag_q     <= flag_d;
            res_data_q <= res_data_d;
            res_flag_q <= res_flag_d;
        end
    end

    assign res_data = res_data_q;
    assign res_flag = res_flag_q;

`ifdef Q2_ALU_SEQ_SELFCHECK_EN
    logic [WIDTH-1:0] gold_data_q, gold_data_d;
    logic             gold_flag_q, gold_flag_d;
    logic             chk_err_q, chk_err_d;

    always_comb begin
        gold_data_d = x_in;
        gold_flag_d = (x_in == '0);
        case (op_code)
            OP_NOR: begin
                gold_data_d = ~(a_in | x_in);
                gold_flag_d = ((a_in | x_in) == {WIDTH{1'b1}});
            end
            OP_ADD: begin
                {gold_flag_d, gold_data_d} = {1'b0, a_in} + {1'b0, x_in} + {{WIDTH{1'b0}}, cin};
            end
            OP_SHR: begin
                gold_data_d = {1'b0, x_in[WIDTH-1:1]};
                gold_flag_d = x_in[0];
            end
            default: begin
                gold_data_d = x_in;
                gold_flag_d = (x_in == '0);
            end
        endcase
    end

    always_comb begin
        chk_err_d = chk_err_q;
        if ((state_q == ST_DONE) &&
            ((res_data_q != gold_data_q) || (res_flag_q != gold_flag_q))) begin
            chk_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gold_data_q <= '0;
            gold_flag_q <= 1'b0;
            chk_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                gold_data_q <= gold_data_d;
                gold_flag_q <= gold_flag_d;
            end
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_q2_alu_seq.sv
// Closed-loop bench: behavioural q2 ALU slice plus a scoreboard of word-level expected results.
module tb_q2_alu_seq;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         op_valid;
    logic         op_ready;
    logic [1:0]   op_code;
    logic [W-1:0] a_in, x_in;
    logic         cin;
    logic         res_valid;
    logic [W-1:0] res_data;
    logic         res_flag;
    logic         alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1;
    logic         alu_out, alu_cout;
    logic         chk_err;

    logic         inv_out = 1'b0;
    logic         corrupt = 1'b0;
    logic         held = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int busy = 0;
    int acc_cnt = 0;
    int last_acc = -1;

    typedef struct {
        logic [W-1:0] data;
        logic         flag;
        int           due;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    q2_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .a_in      (a_in),
        .x_in      (x_in),
        .cin       (cin),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_flag  (res_flag),
        .alu_a0    (alu_a0),
        .alu_x0    (alu_x0),
        .alu_x1    (alu_x1),
        .alu_f     (alu_f),
        .alu_o0    (alu_o0),
        .alu_o1    (alu_o1),
        .alu_out   (alu_out),
        .alu_cout  (alu_cout),
        .chk_err   (chk_err)
    );

    // Single-bit slice: LOAD passes X, NOR, full add, SHR takes the next X bit.
    always_comb begin
        logic raw;
        raw      = 1'b0;
        alu_cout = 1'b0;
        case ({alu_o1, alu_o0})
            2'b00: begin raw = alu_x0;              alu_cout = alu_f & ~raw; end
            2'b01: begin raw = ~(alu_a0 | alu_x0);  alu_cout = alu_f & ~raw; end
            2'b10: begin
                raw      = alu_a0 ^ alu_x0 ^ alu_f;
                alu_cout = (alu_a0 & alu_x0) | (alu_a0 & alu_f) | (alu_x0 & alu_f);
            end
            default: begin raw = alu_x1;            alu_cout = alu_f; end
        endcase
        alu_out = raw ^ inv_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] x, input logic c);
        exp_t e;
        logic [W:0] sum;
        e.due = 0;
        case (op)
            2'b00: begin e.data = x; e.flag = (x == 0); end
            2'b01: begin e.data = ~(a | x); e.flag = (e.data == 0); end
            2'b10: begin
                sum    = {1'b0, a} + {1'b0, x} + {{W{1'b0}}, c};
                e.data = sum[W-1:0];
                e.flag = sum[W];
            end
            default: begin e.data = x >> 1; e.flag = x[0]; end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            busy = 0;
        end else begin
            if (busy <= 1)
                check("alu_idle", {26'd0, alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1}, 32'd0);
            if (busy > 0) begin
                check("rdy_busy", {31'd0, op_ready}, 32'd0);
                busy--;
            end else begin
                check("rdy_idle", {31'd0, op_ready}, 32'd1);
            end
            if (res_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_res", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.due);
                    if (!corrupt) begin
                        check("res_data", {20'd0, res_data}, {20'd0, e.data});
                        check("res_flag", {31'd0, res_flag}, {31'd0, e.flag});
                    end
                end
            end
            if (op_valid && op_ready) begin
                e = model(op_code, a_in, x_in, cin);
                e.due = cyc + W + 1;
                sb.push_back(e);
                busy = W + 1;
                if (held && last_acc >= 0) check("accept_spacing", cyc - last_acc, W + 2);
                last_acc = cyc;
                acc_cnt++;
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] x, input logic c);
        int n;
        @(posedge clk) #1;
        op_code  = op;
        a_in     = a;
        x_in     = x;
        cin      = c;
        op_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!op_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!op_ready) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk) #1;
        op_valid = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] x, input logic c);
        issue(op, a, x, c);
        drain();
    endtask

    initial begin
        int base;
        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_code  = 2'b00;
        a_in     = '0;
        x_in     = '0;
        cin      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_op_ready", {31'd0, op_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_res_data", {20'd0, res_data}, 32'd0);
        check("rst_res_flag", {31'd0, res_flag}, 32'd0);
        check("rst_alu", {26'd0, alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1}, 32'd0);
        check("rst_chk_err", {31'd0, chk_err}, 32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;

        run_op(2'b10, 12'h123, 12'h0FF, 1'b0);
        run_op(2'b10, 12'hFFF, 12'h001, 1'b0);
        run_op(2'b10, 12'h000, 12'h000, 1'b1);
        run_op(2'b01, 12'hF0F, 12'h0F0, 1'b0);
        run_op(2'b01, 12'h000, 12'h000, 1'b0);
        run_op(2'b00, 12'hABC, 12'h000, 1'b0);
        run_op(2'b00, 12'h000, 12'h800, 1'b0);
        run_op(2'b11, 12'h000, 12'h805, 1'b0);
        for (int i = 0; i < 6; i++)
            run_op(2'($urandom_range(3)), 12'($urandom), 12'($urandom), 1'($urandom));

        // op_valid held for 30 cycles: accepts land every WIDTH+2 cycles
        @(posedge clk) #1;
        held     = 1'b1;
        last_acc = -1;
        base     = acc_cnt;
        op_code  = 2'b10;
        a_in     = 12'h321;
        x_in     = 12'h456;
        cin      = 1'b1;
        op_valid = 1'b1;
        repeat (30) @(posedge clk);
        #1 op_valid = 1'b0;
        held = 1'b0;
        check("held_accepts", acc_cnt - base, 32'd3);
        drain();

        // reset mid-RUN aborts the op
        issue(2'b10, 12'h5A5, 12'h111, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_op_ready", {31'd0, op_ready}, 32'd1);
        check("abort_res_valid", {31'd0, res_valid}, 32'd0);
        check("abort_alu", {26'd0, alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1}, 32'd0);
        check("abort_res_data", {20'd0, res_data}, 32'd0);
        @(posedge clk) #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run_op(2'b10, 12'h123, 12'h0FF, 1'b0);

`ifdef Q2_ALU_SEQ_SELFCHECK_EN
        check("chk_err_clean", {31'd0, chk_err}, 32'd0);
        corrupt = 1'b1;
        issue(2'b10, 12'h111, 12'h222, 1'b0);
        repeat (2) @(negedge clk);
        inv_out = 1'b1;
        @(negedge clk);
        inv_out = 1'b0;
        drain();
        corrupt = 1'b0;
        check("chk_err_set", {31'd0, chk_err}, 32'd1);
        run_op(2'b00, 12'h000, 12'h00F, 1'b0);
        check("chk_err_sticky", {31'd0, chk_err}, 32'd1);
`else
        check("chk_err_tied", {31'd0, chk_err}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
